// File: rtl/riscv_pkg.sv
// Shared RV32I load/store width codes and memory access FSM states.
// Imported by the memory access unit and its lane aligner.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } mau_state_e;

  // Reserved width codes are reported as misaligned.
  function automatic logic f3_misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    unique case (f3)
      F3_LB, F3_LBU: m = 1'b0;
      F3_LH, F3_LHU: m = off[0];
      F3_LW:         m = |off;
      default:       m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Load byte/halfword extract and extend, store byte/halfword merge.
// Purely combinational; lane chosen by the low address bits.
module lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  input  logic [31:0] rd_word,
  input  logic [31:0] st_word,
  input  logic [31:0] wdata,
  output logic [31:0] ld,
  output logic [31:0] sd
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rd_word[8*off +: 8];
    h = off[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (f3)
      F3_LB:   ld = {{24{b[7]}}, b};
      F3_LH:   ld = {{16{h[15]}}, h};
      F3_LBU:  ld = {24'd0, b};
      F3_LHU:  ld = {16'd0, h};
      default: ld = rd_word;
    endcase
  end

  always_comb begin
    sd = st_word;
    unique case (f3[1:0])
      2'b00:   sd[8*off +: 8] = wdata[7:0];
      2'b01:   sd[16*off[1] +: 16] = wdata[15:0];
      default: sd = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I load/store unit on a single-port word memory.
// Sub-word stores use read-modify-write.
module mem_access_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            misaligned,
  output logic [XLEN-1:0] mem_a,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  mau_state_e st_q, st_d;
  logic        st_is_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        mis_q;
  logic        mis_now;
  logic [31:0] ld;
  logic [31:0] sd;

  assign mis_now = f3_misaligned(funct3, addr[1:0]);

  lane_align u_lane (
    .f3      (f3_q),
    .off     (addr_q[1:0]),
    .rd_word (mem_rd),
    .st_word (word_q),
    .wdata   (wdata_q),
    .ld      (ld),
    .sd      (sd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      st_is_q <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      st_q <= st_d;
      unique case (st_q)
        S_IDLE: if (req) begin
          st_is_q <= is_store;
          f3_q    <= funct3;
          addr_q  <= addr;
          wdata_q <= wdata;
          mis_q   <= mis_now;
        end
        S_READ: begin
          if (st_is_q) word_q  <= mem_rd;
          else         rdata_q <= ld;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    st_d   = st_q;
    busy   = 1'b1;
    done   = 1'b0;
    mem_we = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        busy = 1'b0;
        if (req) begin
          if (mis_now)
            st_d = S_DONE;
          else if (is_store && funct3 == F3_SW)
            st_d = S_WRITE;
          else
            st_d = S_READ;
        end
      end
      S_READ:  st_d = st_is_q ? S_WRITE : S_DONE;
      S_WRITE: begin
        mem_we = 1'b1;
        st_d   = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        st_d = S_IDLE;
      end
    endcase
  end

  assign mem_a      = {addr_q[31:2], 2'b00};
  assign mem_wd     = sd;
  assign rdata      = rdata_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and random checks of mem_access_unit against a byte-level model.
// Bench memory is 16 words; a separate reference copy tracks expected contents.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, misaligned, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] ref_rd;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .misaligned (misaligned),
    .mem_a      (mem_a),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  assign mem_rd = mem[mem_a[5:2]];

  always @(posedge clk)
    if (mem_we) mem[mem_a[5:2]] <= mem_wd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected behaviour from access size and byte offset arithmetic.
  task automatic run_op(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit hold, input bit now);
    int sz, off, idx, exp_cyc, exp_we, c, we, got, extra;
    bit mis;
    longint unsigned mask, v;
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      3'b010:         sz = 4;
      default:        sz = 0;
    endcase
    off = int'(a % 4);
    idx = int'(a[5:2]);
    mis = (sz == 0) || (int'(a % 32'(sz == 0 ? 1 : sz)) != 0);
    mask = (64'd1 << (8 * sz)) - 1;
    if (!mis && !st) begin
      v = (longint'(ref_mem[idx]) >> (8 * off)) & mask;
      if (f3[2] == 1'b0 && sz < 4 && v[8*sz-1])
        v = v | (~mask);
      ref_rd = v[31:0];
    end
    if (!mis && st) begin
      v = longint'(ref_mem[idx]) & ~(mask << (8 * off));
      v = v | ((longint'(wd) & mask) << (8 * off));
      ref_mem[idx] = v[31:0];
    end
    exp_cyc = mis ? 1 : ((st && sz < 4) ? 3 : 2);
    exp_we  = (!mis && st) ? 1 : 0;

    if (!now) @(negedge clk);
    req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
    c = 1; we = 0; got = 0;
    while (c <= 6) begin
      if (mem_we) we++;
      if (done) begin got = 1; break; end
      @(posedge clk); #1;
      c++;
    end
    req = 1'b0;
    chk("done_cycle", got ? c : 0, exp_cyc);
    chk("misaligned", {31'd0, misaligned}, {31'd0, mis});
    chk("we_pulses", we, exp_we);
    chk("rdata", rdata, ref_rd);
    if (st) chk("mem_word", mem[idx], ref_mem[idx]);
    extra = 0;
    repeat (hold ? 3 : 1) begin
      @(posedge clk); #1;
      if (done || mem_we) extra++;
    end
    chk("idle_busy", {31'd0, busy}, 32'd0);
    if (hold) chk("held_req_extra", extra, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1111_0000 * i + 32'h0102_0304;
    mem[2] = 32'h80FF_7F01;
    mem[1] = 32'h0000_0000;
    for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
    ref_rd = 32'd0;

    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 3'b000, 32'h9, 32'h0, 1'b0, 1'b1);
    chk("lb_9", rdata, 32'h0000_007F);
    run_op(1'b0, 3'b101, 32'hA, 32'h0, 1'b0, 1'b0);
    chk("lhu_A", rdata, 32'h0000_80FF);
    run_op(1'b0, 3'b001, 32'hA, 32'h0, 1'b0, 1'b0);
    chk("lh_A", rdata, 32'hFFFF_80FF);
    run_op(1'b1, 3'b000, 32'h9, 32'hAA, 1'b0, 1'b0);
    chk("sb_9", mem[2], 32'h80FF_AA01);
    run_op(1'b1, 3'b010, 32'h4, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("sw_4", mem[1], 32'hDEAD_BEEF);
    run_op(1'b0, 3'b010, 32'h6, 32'h0, 1'b0, 1'b0);
    run_op(1'b1, 3'b001, 32'h3, 32'h5555, 1'b0, 1'b0);
    run_op(1'b0, 3'b111, 32'h0, 32'h0, 1'b0, 1'b0);
    run_op(1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, 1'b1, 1'b0);

    // Reset while a halfword store sits in its read phase.
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; funct3 = 3'b001;
    addr = 32'h8; wdata = 32'h1234;
    @(posedge clk); #1;
    req = 1'b0;
    chk("sh_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_we", {31'd0, mem_we}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_mis", {31'd0, misaligned}, 32'd0);
    chk("arst_mem_a", mem_a, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("arst_word", mem[2], ref_mem[2]);
    ref_rd = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 40; n++) begin
      logic st;
      logic [2:0] f3;
      logic [2:0] codes [8];
      codes = '{3'b000, 3'b001, 3'b010, 3'b100,
                3'b101, 3'b011, 3'b110, 3'b111};
      st = 1'($urandom_range(0, 1));
      f3 = st ? codes[$urandom_range(0, 2)] : codes[$urandom_range(0, 7)];
      run_op(st, f3, 32'($urandom_range(0, 63)), $urandom,
             1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
